// File: rtl/oblivious_transfer_sender.sv
// Sender side of a 1-of-2 RSA oblivious transfer: publishes N, e, x0, x1, receives v,
// blinds m0/m1 with k_i = (v - x_i)^d mod N via an external modexp engine, and sends m0', m1'.
module oblivious_transfer_sender (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] n_in,
    input  logic [31:0] e_in,
    input  logic [31:0] d_in,
    input  logic [31:0] x0_in,
    input  logic [31:0] x1_in,
    input  logic [31:0] m0_in,
    input  logic [31:0] m1_in,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        me_start,
    output logic [31:0] me_base,
    output logic [31:0] me_exp,
    output logic [31:0] me_mod,
    input  logic        me_done,
    input  logic [31:0] me_res,
    output logic        done,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, SEND1, RECV, SUB0, EXP0, SUB1, EXP1, PACK, SEND2, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_nxt;
    logic [31:0] n_q, n_d, e_q, e_d, d_q, d_d;
    logic [31:0] x0_q, x0_d, x1_q, x1_d, m0_q, m0_d, m1_q, m1_d;
    logic [31:0] v_q, v_d, k0_q, k0_d, k1_q, k1_d, m0p_q, m0p_d, m1p_q, m1p_d;
    logic        tx_valid_q, tx_valid_d, rx_ready_q, rx_ready_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        me_start_q, me_start_d, done_q, done_d, busy_q, busy_d;
    logic [31:0] me_base_q, me_base_d, me_exp_q, me_exp_d, me_mod_q, me_mod_d;
    logic        tx_xfer, rx_xfer;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // v and x are both below n, so the wrapped result always fits in 32 bits
    function automatic logic [31:0] sub_mod(input logic [31:0] v, input logic [31:0] x,
                                            input logic [31:0] n);
        if (v >= x)
            return v - x;
        return 32'({1'b0, v} + {1'b0, n} - {1'b0, x});
    endfunction

    function automatic logic [31:0] add_mod(input logic [31:0] a, input logic [31:0] k,
                                            input logic [31:0] n);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, k};
        if (s >= {1'b0, n})
            return 32'(s - {1'b0, n});
        return s[31:0];
    endfunction

    function automatic logic [7:0] send1_byte(input logic [3:0] idx, input logic [31:0] n,
                                              input logic [31:0] e, input logic [31:0] x0,
                                              input logic [31:0] x1);
        logic [31:0] w;
        case (idx[3:2])
            2'd0: w = n;
            2'd1: w = e;
            2'd2: w = x0;
            default: w = x1;
        endcase
        return byte_of(w, idx[1:0]);
    endfunction

    assign tx_xfer = tx_valid_q && tx_ready;
    assign rx_xfer = rx_valid && rx_ready_q;
    assign cnt_nxt = cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        e_d        = e_q;
        d_d        = d_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        m0_d       = m0_q;
        m1_d       = m1_q;
        v_d        = v_q;
        k0_d       = k0_q;
        k1_d       = k1_q;
        m0p_d      = m0p_q;
        m1p_d      = m1p_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rx_ready_d = rx_ready_q;
        me_start_d = 1'b0;
        me_base_d  = me_base_q;
        me_exp_d   = me_exp_q;
        me_mod_d   = me_mod_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = n_in;
                    e_d        = e_in;
                    d_d        = d_in;
                    x0_d       = x0_in;
                    x1_d       = x1_in;
                    m0_d       = m0_in;
                    m1_d       = m1_in;
                    cnt_d      = 4'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = n_in[7:0];
                    state_d    = SEND1;
                end
            end
            SEND1: begin
                if (tx_xfer) begin
                    if (cnt_q == 4'd15) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'd0;
                        cnt_d      = 4'd0;
                        rx_ready_d = 1'b1;
                        state_d    = RECV;
                    end else begin
                        cnt_d     = cnt_nxt;
                        tx_data_d = send1_byte(cnt_nxt, n_q, e_q, x0_q, x1_q);
                    end
                end
            end
            RECV: begin
                if (rx_xfer) begin
                    case (cnt_q[1:0])
                        2'd0: v_d[7:0]   = rx_data;
                        2'd1: v_d[15:8]  = rx_data;
                        2'd2: v_d[23:16] = rx_data;
                        default: v_d[31:24] = rx_data;
                    endcase
                    if (cnt_q == 4'd3) begin
                        cnt_d      = 4'd0;
                        rx_ready_d = 1'b0;
                        state_d    = SUB0;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            SUB0: begin
                me_base_d  = sub_mod(v_q, x0_q, n_q);
                me_exp_d   = d_q;
                me_mod_d   = n_q;
                me_start_d = 1'b1;
                state_d    = EXP0;
            end
            // a done coincident with our own start pulse belongs to no request of ours
            EXP0: begin
                if (me_done && !me_start_q) begin
                    k0_d    = me_res;
                    state_d = SUB1;
                end
            end
            SUB1: begin
                me_base_d  = sub_mod(v_q, x1_q, n_q);
                me_exp_d   = d_q;
                me_mod_d   = n_q;
                me_start_d = 1'b1;
                state_d    = EXP1;
            end
            EXP1: begin
                if (me_done && !me_start_q) begin
                    k1_d    = me_res;
                    state_d = PACK;
                end
            end
            PACK: begin
                m0p_d      = add_mod(m0_q, k0_q, n_q);
                m1p_d      = add_mod(m1_q, k1_q, n_q);
                cnt_d      = 4'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = m0p_d[7:0];
                state_d    = SEND2;
            end
            SEND2: begin
                if (tx_xfer) begin
                    if (cnt_q == 4'd7) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'd0;
                        cnt_d      = 4'd0;
                        state_d    = DONE;
                    end else begin
                        cnt_d     = cnt_nxt;
                        tx_data_d = byte_of(cnt_nxt[2] ? m1p_q : m0p_q, cnt_nxt[1:0]);
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            n_q        <= 32'd0;
            e_q        <= 32'd0;
            d_q        <= 32'd0;
            x0_q       <= 32'd0;
            x1_q       <= 32'd0;
            m0_q       <= 32'd0;
            m1_q       <= 32'd0;
            v_q        <= 32'd0;
            k0_q       <= 32'd0;
            k1_q       <= 32'd0;
            m0p_q      <= 32'd0;
            m1p_q      <= 32'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            rx_ready_q <= 1'b0;
            me_start_q <= 1'b0;
            me_base_q  <= 32'd0;
            me_exp_q   <= 32'd0;
            me_mod_q   <= 32'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            e_q        <= e_d;
            d_q        <= d_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            v_q        <= v_d;
            k0_q       <= k0_d;
            k1_q       <= k1_d;
            m0p_q      <= m0p_d;
            m1p_q      <= m1p_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            me_start_q <= me_start_d;
            me_base_q  <= me_base_d;
            me_exp_q   <= me_exp_d;
            me_mod_q   <= me_mod_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign rx_ready = rx_ready_q;
    assign me_start = me_start_q;
    assign me_base  = me_base_q;
    assign me_exp   = me_exp_q;
    assign me_mod   = me_mod_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_oblivious_transfer_sender.sv
// Scoreboard bench for oblivious_transfer_sender with a behavioural modexp engine.
module tb_oblivious_transfer_sender;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] n_in, e_in, d_in, x0_in, x1_in, m0_in, m1_in;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]  tx_data, rx_data;
    logic        me_start, me_done, done, busy;
    logic [31:0] me_base, me_exp, me_mod, me_res;

    always #5 clk = ~clk;

    oblivious_transfer_sender dut (
        .clk(clk), .reset(reset), .start(start),
        .n_in(n_in), .e_in(e_in), .d_in(d_in), .x0_in(x0_in), .x1_in(x1_in),
        .m0_in(m0_in), .m1_in(m1_in),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
        .me_done(me_done), .me_res(me_res), .done(done), .busy(busy)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_base[$], exp_exp[$], exp_mod[$];
    bit          rand_ready = 1'b0;
    bit          inject_en = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;
    int          me_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] r, bb;
        r  = 64'd1;
        bb = 64'(b) % 64'(m);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * bb) % 64'(m);
            bb = (bb * bb) % 64'(m);
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] sub_mod_m(input logic [31:0] v, input logic [31:0] x,
                                              input logic [31:0] n);
        return 32'((64'(v) + 64'(n) - 64'(x)) % 64'(n));
    endfunction

    function automatic logic [31:0] add_mod_m(input logic [31:0] a, input logic [31:0] k,
                                              input logic [31:0] n);
        return 32'((64'(a) + 64'(k)) % 64'(n));
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // tx monitor: byte order, no loss/duplication, stability under backpressure
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid) chk("rx_ready_while_tx", {31'd0, rx_ready}, 32'd0);
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail_now("tx_extra_byte");
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset && me_start) begin
            if (exp_base.size() == 0) begin
                fail_now("me_extra_start");
            end else begin
                chk("me_base", me_base, exp_base.pop_front());
                chk("me_exp", me_exp, exp_exp.pop_front());
                chk("me_mod", me_mod, exp_mod.pop_front());
            end
        end
    end

    // engine: a bogus done on the start cycle, then the real result three cycles later
    initial begin
        me_done = 1'b0;
        me_res  = 32'd0;
        forever begin
            @(negedge clk);
            if (me_start && !reset) begin
                logic [31:0] r;
                me_done = 1'b1;
                me_res  = 32'hDEAD_BEEF;
                @(posedge clk);
                #1;
                me_done = 1'b0;
                me_res  = 32'd0;
                repeat (3) @(negedge clk);
                r = (ovr_en && me_cnt == 1) ? ovr_val : modexp(me_base, me_exp, me_mod);
                me_cnt++;
                me_done = 1'b1;
                me_res  = r;
                @(posedge clk);
                #1;
                me_done = 1'b0;
                me_res  = 32'd0;
            end
        end
    end

    task automatic scramble_inputs();
        n_in  = 32'h0BAD_0001;
        e_in  = 32'h0BAD_0002;
        d_in  = 32'h0BAD_0003;
        x0_in = 32'h0BAD_0004;
        x1_in = 32'h0BAD_0005;
        m0_in = 32'h0BAD_0006;
        m1_in = 32'h0BAD_0007;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (inject_en && me_start) begin
                inject_en = 1'b0;
                start = 1'b1;
                scramble_inputs();
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_me_start"}, {31'd0, me_start}, 32'd0);
        chk({tag, "_me_base"}, me_base, 32'd0);
        chk({tag, "_me_exp"}, me_exp, 32'd0);
        chk({tag, "_me_mod"}, me_mod, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        start    = 1'b0;
        rand_ready = 1'b0;
        exp_tx.delete();
        exp_base.delete();
        exp_exp.delete();
        exp_mod.delete();
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero(tag);
        reset = 1'b0;
    endtask

    task automatic measure(input int expect_len, input string name);
        int w = 0;
        int cnt = 0;
        while (!tx_valid && w < 500) begin
            @(negedge clk);
            w++;
        end
        while (tx_valid && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, expect_len);
    endtask

    task automatic send_v(input logic [31:0] v, input int nbytes);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        for (int i = 0; i < nbytes; i++) begin
            int w = 0;
            @(negedge clk);
            while (!rx_ready && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (!rx_ready) begin
                fail_now("rx_ready_timeout");
                break;
            end
            rx_data = v[8*i +: 8];
            @(posedge clk);
            #1;
            rx_data = 8'hEE;
        end
    endtask

    task automatic run(input logic [31:0] n, input logic [31:0] e, input logic [31:0] d,
                       input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] m0,
                       input logic [31:0] m1, input logic [31:0] v, input bit rnd,
                       input bit inj, input bit ovr, input logic [31:0] ovr_v, input int nv);
        logic [31:0] t0, t1, k0, k1;
        int w = 0;
        t0 = sub_mod_m(v, x0, n);
        t1 = sub_mod_m(v, x1, n);
        k0 = modexp(t0, d, n);
        k1 = ovr ? ovr_v : modexp(t1, d, n);
        push_word(n);
        push_word(e);
        push_word(x0);
        push_word(x1);
        if (nv == 4) begin
            exp_base.push_back(t0); exp_exp.push_back(d); exp_mod.push_back(n);
            exp_base.push_back(t1); exp_exp.push_back(d); exp_mod.push_back(n);
            push_word(add_mod_m(m0, k0, n));
            push_word(add_mod_m(m1, k1, n));
        end
        ovr_en = ovr;
        ovr_val = ovr_v;
        me_cnt = 0;
        rand_ready = rnd;
        inject_en = inj;
        n_in = n; e_in = e; d_in = d; x0_in = x0; x1_in = x1; m0_in = m0; m1_in = m1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        fork
            begin
                if (!rnd) measure(16, "send1_cycles");
            end
            send_v(v, nv);
        join
        if (nv == 4) begin
            if (!rnd) measure(8, "send2_cycles");
            while (!done && w < 3000) begin
                @(negedge clk);
                w++;
            end
            chk("done", {31'd0, done}, 32'd1);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            chk("tx_bytes_left", exp_tx.size(), 32'd0);
            chk("me_calls_left", exp_base.size(), 32'd0);
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        do_reset("por");

        // classic RSA pair N=3233, e=17, d=2753: t0=3086 gives k0=5, m0'=47
        run(32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd42, 32'd7, 32'd3186,
            1'b0, 1'b0, 1'b0, 32'd0, 4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_holds", {31'd0, done}, 32'd1);
        chk("no_restart_tx", {31'd0, tx_valid}, 32'd0);
        do_reset("rst1");

        // wrap cases under random backpressure and a start pulse in EXP0
        run(32'd3233, 32'd17, 32'd2753, 32'd100, 32'd3200, 32'd3231, 32'd3230, 32'd3186,
            1'b1, 1'b1, 1'b1, 32'd10, 4);
        do_reset("rst2");

        run(32'hFFFF_FFFB, 32'h0001_0001, 32'h1234_5677, 32'hFFFF_FF00, 32'd5,
            32'hFFFF_FFF0, 32'd1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'd0, 2);
        do_reset("mid_recv");
        run(32'hFFFF_FFFB, 32'h0001_0001, 32'h1234_5677, 32'hFFFF_FF00, 32'd5,
            32'hFFFF_FFF0, 32'd1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'd0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

endmodule
